grom_wb_arb: RTL and testbench

Two-master Wishbone arbiter in front of the GROM access slave port. It shares the single GROM image port between the boot-time image loader (master 0) and the debug/monitor master (master 1). It grants one master per bus cycle (`cyc`) in round-robin order and switches grant with zero bubble cycles. It also runs a per-strobe ack watchdog that returns an error instead of letting a master hang.

---
 rtl/mega99_wb_pkg.sv | 18 +
 rtl/wb_ack_watchdog.sv | 32 +++
 rtl/grom_wb_arb.sv | 136 +++++++++++++
 tb/tb_grom_wb_arb.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mega99_wb_pkg.sv
// Shared Wishbone widths and grant encodings.
// Grant vectors are [0:1]: bit 0 = master 0.
package mega99_wb_pkg;
  localparam int WB_ADR_W = 16;
  localparam int WB_DAT_W = 8;

  typedef logic [0:1] gnt_t;

  localparam gnt_t GNT_NONE = 2'b00;
  localparam gnt_t GNT_M0   = 2'b10;
  localparam gnt_t GNT_M1   = 2'b01;

  typedef enum logic [0:1] {
    IDLE = 2'b00,
    G0   = 2'b10,
    G1   = 2'b01
  } arb_state_t;
endpackage

// File: rtl/wb_ack_watchdog.sv
// Per-strobe ack watchdog: errors out a strobe
// that waits TIMEOUT cycles without an ack.
module wb_ack_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stb,
  input  logic ack,
  input  logic clr,
  output logic err,
  output logic slv_stb
);
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] wd;
  logic [7:0] wd_nxt;

  assign err     = stb & ~ack & (wd == LIMIT);
  assign slv_stb = stb & ~err;

  always_comb begin
    wd_nxt = wd + 8'd1;
    if (clr || !stb || ack || err)
      wd_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd <= '0;
    else        wd <= wd_nxt;
  end
endmodule

// File: rtl/grom_wb_arb.sv
// Round-robin two-master Wishbone arbiter for
// the GROM image port, with an ack watchdog.
module grom_wb_arb
  import mega99_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [0:WB_ADR_W-1] m0_adr_i,
  input  logic [0:WB_DAT_W-1] m0_dat_i,
  input  logic                m0_we_i,
  input  logic [0:0]          m0_sel_i,
  input  logic                m0_stb_i,
  input  logic                m0_cyc_i,
  output logic [0:WB_DAT_W-1] m0_dat_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  input  logic [0:WB_ADR_W-1] m1_adr_i,
  input  logic [0:WB_DAT_W-1] m1_dat_i,
  input  logic                m1_we_i,
  input  logic [0:0]          m1_sel_i,
  input  logic                m1_stb_i,
  input  logic                m1_cyc_i,
  output logic [0:WB_DAT_W-1] m1_dat_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic [0:WB_ADR_W-1] s_adr_o,
  output logic [0:WB_DAT_W-1] s_dat_o,
  output logic                s_we_o,
  output logic [0:0]          s_sel_o,
  output logic                s_stb_o,
  output logic                s_cyc_o,
  input  logic [0:WB_DAT_W-1] s_dat_i,
  input  logic                s_ack_i,
  output logic [0:1]          grant_o
);
  arb_state_t state;
  arb_state_t state_nxt;
  logic       last;
  logic       last_nxt;
  logic       g0;
  logic       g1;
  logic       stb;
  logic       err;

  assign g0 = (state == G0);
  assign g1 = (state == G1);
  assign grant_o = gnt_t'(state);

  // last = 1 means m1 was served last, so m0 wins a tie
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    unique case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i)
          state_nxt = last ? G0 : G1;
        else if (m0_cyc_i)
          state_nxt = G0;
        else if (m1_cyc_i)
          state_nxt = G1;
      end
      G0: begin
        if (!m0_cyc_i) begin
          state_nxt = m1_cyc_i ? G1 : IDLE;
          last_nxt  = 1'b0;
        end
      end
      G1: begin
        if (!m1_cyc_i) begin
          state_nxt = m0_cyc_i ? G0 : IDLE;
          last_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_cyc_o = 1'b0;
    stb     = 1'b0;
    unique case (1'b1)
      g0: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_cyc_o = m0_cyc_i;
        stb     = m0_stb_i;
      end
      g1: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_cyc_o = m1_cyc_i;
        stb     = m1_stb_i;
      end
      default: ;
    endcase
  end

  wb_ack_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .stb    (stb),
    .ack    (s_ack_i),
    .clr    (state_nxt != state),
    .err    (err),
    .slv_stb(s_stb_o)
  );

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & g0;
  assign m1_ack_o = s_ack_i & g1;
  assign m0_err_o = err & g0;
  assign m1_err_o = err & g1;
endmodule

// File: tb/tb_grom_wb_arb.sv
// Directed table-driven bench for grom_wb_arb
// plus a hand-written async reset sequence.
module tb_grom_wb_arb;
  import mega99_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:15] m0_adr_i, m1_adr_i, s_adr_o;
  logic [0:7]  m0_dat_i, m1_dat_i, s_dat_o;
  logic [0:7]  m0_dat_o, m1_dat_o, s_dat_i;
  logic        m0_we_i, m1_we_i, s_we_o;
  logic [0:0]  m0_sel_i, m1_sel_i, s_sel_o;
  logic        m0_stb_i, m1_stb_i, s_stb_o;
  logic        m0_cyc_i, m1_cyc_i, s_cyc_o;
  logic        m0_ack_o, m1_ack_o, s_ack_i;
  logic        m0_err_o, m1_err_o;
  logic [0:1]  grant_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  grom_wb_arb #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o)
  );

  typedef struct {
    bit         rst;
    bit         c0, s0, w0;
    bit         c1, s1, w1;
    bit         ack;
    logic [7:0] sdat;
    logic [1:0] gnt;
    bit         scyc, sstb;
    bit         a0, a1, e0, e1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    bit rst, bit c0, bit s0, bit w0,
    bit c1, bit s1, bit w1,
    bit ack, logic [7:0] sdat,
    logic [1:0] gnt, bit scyc, bit sstb,
    bit a0, bit a1, bit e0, bit e1);
    vec_t t;
    t.rst = rst;
    t.c0 = c0; t.s0 = s0; t.w0 = w0;
    t.c1 = c1; t.s1 = s1; t.w1 = w1;
    t.ack = ack; t.sdat = sdat;
    t.gnt = gnt; t.scyc = scyc; t.sstb = sstb;
    t.a0 = a0; t.a1 = a1; t.e0 = e0; t.e1 = e1;
    return t;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h",
               name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    m0_cyc_i = t.c0; m0_stb_i = t.s0;
    m0_we_i  = t.w0;
    m1_cyc_i = t.c1; m1_stb_i = t.s1;
    m1_we_i  = t.w1;
    s_ack_i  = t.ack; s_dat_i = t.sdat;
  endtask

  task automatic check_vec(input int i,
                           input vec_t t);
    logic [15:0] ea;
    logic [7:0]  ed;
    logic        es, ew;
    ea = '0; ed = '0; es = 1'b0; ew = 1'b0;
    if (t.gnt == 2'b10) begin
      ea = 16'h0800; ed = 8'hA5;
      es = 1'b1; ew = t.w0;
    end else if (t.gnt == 2'b01) begin
      ea = 16'h1234; ed = 8'h3C;
      es = 1'b0; ew = t.w1;
    end
    chk($sformatf("v%0d grant", i), 32'(grant_o), 32'(t.gnt));
    chk($sformatf("v%0d s_cyc", i), 32'(s_cyc_o), 32'(t.scyc));
    chk($sformatf("v%0d s_stb", i), 32'(s_stb_o), 32'(t.sstb));
    chk($sformatf("v%0d s_adr", i), 32'(s_adr_o), 32'(ea));
    chk($sformatf("v%0d s_dat", i), 32'(s_dat_o), 32'(ed));
    chk($sformatf("v%0d s_sel", i), 32'(s_sel_o), 32'(es));
    chk($sformatf("v%0d s_we", i), 32'(s_we_o), 32'(ew));
    chk($sformatf("v%0d m0_ack", i), 32'(m0_ack_o), 32'(t.a0));
    chk($sformatf("v%0d m1_ack", i), 32'(m1_ack_o), 32'(t.a1));
    chk($sformatf("v%0d m0_err", i), 32'(m0_err_o), 32'(t.e0));
    chk($sformatf("v%0d m1_err", i), 32'(m1_err_o), 32'(t.e1));
    chk($sformatf("v%0d m0_dat", i), 32'(m0_dat_o), 32'(t.sdat));
    chk($sformatf("v%0d m1_dat", i), 32'(m1_dat_o), 32'(t.sdat));
  endtask

  initial begin
    m0_adr_i = 16'h0800; m0_dat_i = 8'hA5;
    m0_sel_i = 1'b1;
    m1_adr_i = 16'h1234; m1_dat_i = 8'h3C;
    m1_sel_i = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0;
    s_ack_i = 1'b1; s_dat_i = 8'hC3;

    // rst c0 s0 w0 c1 s1 w1 ack sdat gnt scyc sstb a0 a1 e0 e1
    // single write by m0 (combinational slave ack)
    tbl.push_back(v(1,1,1,1,0,0,0,0,8'h00,2'b00,0,0,0,0,0,0));
    tbl.push_back(v(0,1,1,1,0,0,0,1,8'h00,2'b10,1,1,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,8'h00,2'b10,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,8'h00,2'b00,0,0,0,0,0,0));
    // single read by m1 (registered slave ack)
    tbl.push_back(v(0,0,0,0,1,1,0,0,8'h00,2'b00,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1,1,0,0,8'h00,2'b01,1,1,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1,1,0,1,8'h5A,2'b01,1,1,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,8'h00,2'b01,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,8'h00,2'b00,0,0,0,0,0,0));
    // tie from reset, zero-bubble handoffs
    tbl.push_back(v(1,1,1,0,1,1,0,0,8'h11,2'b00,0,0,0,0,0,0));
    tbl.push_back(v(0,1,1,0,1,1,0,0,8'h11,2'b10,1,1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,1,1,0,0,8'h11,2'b10,1,1,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1,1,0,0,8'h11,2'b10,0,0,0,0,0,0));
    tbl.push_back(v(0,1,1,0,1,1,0,0,8'h11,2'b01,1,1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,1,1,0,0,8'h11,2'b01,1,1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,0,0,0,8'h11,2'b01,0,0,0,0,0,0));
    tbl.push_back(v(0,1,1,0,1,1,0,0,8'h11,2'b10,1,1,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,8'h11,2'b10,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,8'h11,2'b00,0,0,0,0,0,0));
    // watchdog, TIMEOUT=4, m1 waiting throughout
    tbl.push_back(v(0,1,1,0,0,0,0,0,8'h22,2'b00,0,0,0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,0,0,0,8'h22,2'b10,1,1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,1,1,0,0,8'h22,2'b10,1,1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,1,1,0,0,8'h22,2'b10,1,1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,1,1,0,0,8'h22,2'b10,1,0,0,0,1,0));
    tbl.push_back(v(0,1,1,0,1,1,0,0,8'h22,2'b10,1,1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,1,1,0,0,8'h22,2'b10,1,1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,1,1,0,0,8'h22,2'b10,1,1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,1,1,0,0,8'h22,2'b10,1,0,0,0,1,0));
    // ack exactly in the timeout cycle
    tbl.push_back(v(0,1,1,0,1,1,0,0,8'h22,2'b10,1,1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,1,1,0,0,8'h22,2'b10,1,1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,1,1,0,0,8'h22,2'b10,1,1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,1,1,0,1,8'h77,2'b10,1,1,1,0,0,0));
    tbl.push_back(v(0,0,0,0,1,1,0,0,8'h22,2'b10,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1,1,0,1,8'h66,2'b01,1,1,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,8'h22,2'b01,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,8'h22,2'b00,0,0,0,0,0,0));

    // reset state with busy inputs
    repeat (2) @(posedge clk);
    #2;
    chk("rst grant", 32'(grant_o), 32'(GNT_NONE));
    chk("rst s_cyc", 32'(s_cyc_o), 0);
    chk("rst s_stb", 32'(s_stb_o), 0);
    chk("rst s_adr", 32'(s_adr_o), 0);
    chk("rst m0_ack", 32'(m0_ack_o), 0);
    chk("rst m1_ack", 32'(m1_ack_o), 0);
    chk("rst m0_err", 32'(m0_err_o), 0);
    chk("rst m0_dat", 32'(m0_dat_o), 32'hC3);
    chk("rst m1_dat", 32'(m1_dat_o), 32'hC3);

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      if (tbl[i].rst) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      drive(tbl[i]);
      #2;
      check_vec(i, tbl[i]);
    end

    // async reset in the middle of an m1 read
    @(posedge clk);
    #1;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    m1_we_i = 1'b0; s_ack_i = 1'b0;
    #2;
    chk("ar req grant", 32'(grant_o), 32'(GNT_NONE));
    @(posedge clk);
    #3;
    chk("ar g1 grant", 32'(grant_o), 32'(GNT_M1));
    chk("ar g1 s_cyc", 32'(s_cyc_o), 1);
    #1;
    rst_n = 1'b0;
    s_ack_i = 1'b1;
    #1;
    chk("ar async grant", 32'(grant_o), 32'(GNT_NONE));
    chk("ar async s_cyc", 32'(s_cyc_o), 0);
    chk("ar async s_stb", 32'(s_stb_o), 0);
    chk("ar async m1_ack", 32'(m1_ack_o), 0);
    @(posedge clk);
    #2;
    chk("ar hold m1_ack", 32'(m1_ack_o), 0);
    rst_n = 1'b1;
    #1;
    chk("ar rel grant", 32'(grant_o), 32'(GNT_NONE));
    chk("ar rel m1_ack", 32'(m1_ack_o), 0);
    @(posedge clk);
    #1;
    s_ack_i = 1'b0;
    #1;
    chk("ar regrant", 32'(grant_o), 32'(GNT_M1));
    chk("ar regrant s_cyc", 32'(s_cyc_o), 1);
    chk("ar regrant s_stb", 32'(s_stb_o), 1);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("ar end grant", 32'(grant_o), 32'(GNT_NONE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
